// File: rtl/cache_fill_if.sv
// Cache/memory signal bundle for the miss-handling controller.
// The controller is the master: it drives memory requests and array writes.
interface cache_fill_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 3
);
  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              victim_dirty;
  logic [ADDR_W-1:0] victim_address;
  logic [DATA_W-1:0] wb_rdata;
  logic              mem_ready;
  logic              mem_data_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic              fsm_busy;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [CNT_W-1:0]  wb_index;
  logic              write_data_array;
  logic [CNT_W-1:0]  fill_index;
  logic [DATA_W-1:0] fill_data;
  logic              write_tag_array;

  modport master (
    input  miss_detected, miss_address, victim_dirty, victim_address, wb_rdata,
           mem_ready, mem_data_valid, mem_rdata,
    output fsm_busy, mem_req, mem_we, mem_address, mem_wdata, wb_index,
           write_data_array, fill_index, fill_data, write_tag_array
  );

  modport slave (
    output miss_detected, miss_address, victim_dirty, victim_address, wb_rdata,
           mem_ready, mem_data_valid, mem_rdata,
    input  fsm_busy, mem_req, mem_we, mem_address, mem_wdata, wb_index,
           write_data_array, fill_index, fill_data, write_tag_array
  );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Write-back cache miss handler: optional dirty-victim write-back, then a line
// fill with up to MAX_OUTSTANDING pipelined reads returning in order.
//
// state | meaning
// IDLE  | waiting for a miss; latches line/victim bases
// WB    | writing the dirty victim line back, one word per accepted request
// FILL  | issuing reads and writing returned words into the data array
module cache_fill_ctrl #(
  parameter int ADDR_W          = 16,
  parameter int WORD_BYTES      = 2,
  parameter int BLOCK_WORDS     = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic           clk,
  input logic           rst,
  cache_fill_if.master  bus
);
  localparam int BO_W   = $clog2(WORD_BYTES);
  localparam int CNT_W  = $clog2(BLOCK_WORDS);
  localparam int OFF_W  = CNT_W + BO_W;
  localparam int OST_W  = $clog2(MAX_OUTSTANDING) + 1;
  localparam int BASE_W = ADDR_W - OFF_W;

  typedef logic [CNT_W:0]      cnt_t;
  typedef logic [OST_W-1:0]    ost_t;
  typedef logic [BASE_W-1:0]   base_t;
  typedef logic [ADDR_W-1:0]   addr_t;
  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

  localparam cnt_t BLK     = cnt_t'(BLOCK_WORDS);
  localparam cnt_t LAST    = cnt_t'(BLOCK_WORDS - 1);
  localparam ost_t MAX_OST = ost_t'(MAX_OUTSTANDING);

  state_t state_q, state_d;
  base_t  line_base_q, line_base_d, victim_base_q, victim_base_d;
  cnt_t   req_cnt_q, req_cnt_d, resp_cnt_q, resp_cnt_d;
  ost_t   ost_q, ost_d;
  logic   issue, rsp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      line_base_q   <= '0;
      victim_base_q <= '0;
      req_cnt_q     <= '0;
      resp_cnt_q    <= '0;
      ost_q         <= '0;
    end else begin
      state_q       <= state_d;
      line_base_q   <= line_base_d;
      victim_base_q <= victim_base_d;
      req_cnt_q     <= req_cnt_d;
      resp_cnt_q    <= resp_cnt_d;
      ost_q         <= ost_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    line_base_d          = line_base_q;
    victim_base_d        = victim_base_q;
    req_cnt_d            = req_cnt_q;
    resp_cnt_d           = resp_cnt_q;
    ost_d                = ost_q;
    issue                = 1'b0;
    rsp                  = 1'b0;
    bus.fsm_busy         = 1'b0;
    bus.mem_req          = 1'b0;
    bus.mem_we           = 1'b0;
    bus.mem_address      = '0;
    bus.mem_wdata        = '0;
    bus.wb_index         = '0;
    bus.write_data_array = 1'b0;
    bus.fill_index       = '0;
    bus.fill_data        = '0;
    bus.write_tag_array  = 1'b0;
    case (state_q)
      IDLE: begin
        bus.fsm_busy = bus.miss_detected;
        if (bus.miss_detected) begin
          line_base_d   = bus.miss_address[ADDR_W-1:OFF_W];
          victim_base_d = bus.victim_address[ADDR_W-1:OFF_W];
          req_cnt_d     = '0;
          resp_cnt_d    = '0;
          ost_d         = '0;
          state_d       = bus.victim_dirty ? WB : FILL;
        end
      end
      WB: begin
        bus.fsm_busy    = 1'b1;
        bus.mem_we      = 1'b1;
        bus.mem_req     = (req_cnt_q < BLK);
        bus.mem_address = addr_t'({victim_base_q, req_cnt_q[CNT_W-1:0]}) << BO_W;
        bus.wb_index    = req_cnt_q[CNT_W-1:0];
        bus.mem_wdata   = bus.wb_rdata;
        issue           = bus.mem_req & bus.mem_ready;
        if (issue) begin
          if (req_cnt_q == LAST) begin
            req_cnt_d = '0;
            state_d   = FILL;
          end else begin
            req_cnt_d = req_cnt_q + cnt_t'(1);
          end
        end
      end
      FILL: begin
        bus.fsm_busy    = 1'b1;
        bus.mem_req     = (req_cnt_q < BLK) && (ost_q < MAX_OST);
        bus.mem_address = addr_t'({line_base_q, req_cnt_q[CNT_W-1:0]}) << BO_W;
        issue           = bus.mem_req & bus.mem_ready;
        // Returns with nothing outstanding are stray and must not touch the array.
        rsp             = bus.mem_data_valid && (ost_q != '0);
        if (issue) req_cnt_d = req_cnt_q + cnt_t'(1);
        if (issue && !rsp) ost_d = ost_q + ost_t'(1);
        else if (rsp && !issue) ost_d = ost_q - ost_t'(1);
        if (rsp) begin
          bus.write_data_array = 1'b1;
          bus.fill_index       = resp_cnt_q[CNT_W-1:0];
          bus.fill_data        = bus.mem_rdata;
          resp_cnt_d           = resp_cnt_q + cnt_t'(1);
          if (resp_cnt_q == LAST) begin
            bus.write_tag_array = 1'b1;
            state_d             = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset silences every output immediately so an aborted miss writes nothing.
    if (rst) begin
      bus.fsm_busy         = 1'b0;
      bus.mem_req          = 1'b0;
      bus.mem_we           = 1'b0;
      bus.mem_address      = '0;
      bus.mem_wdata        = '0;
      bus.wb_index         = '0;
      bus.write_data_array = 1'b0;
      bus.fill_index       = '0;
      bus.fill_data        = '0;
      bus.write_tag_array  = 1'b0;
    end
  end
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: default instance plus a 32-bit,
// 4-word-line, single-outstanding variant sharing clock and reset.
module tb_cache_fill_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_fill_if #(.ADDR_W(16), .DATA_W(16), .CNT_W(3)) bus ();
  cache_fill_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(2)) vbus ();

  cache_fill_ctrl #(.ADDR_W(16), .WORD_BYTES(2), .BLOCK_WORDS(8), .MAX_OUTSTANDING(4))
    dut (.clk(clk), .rst(rst), .bus(bus));
  cache_fill_ctrl #(.ADDR_W(32), .WORD_BYTES(4), .BLOCK_WORDS(4), .MAX_OUTSTANDING(1))
    vdut (.clk(clk), .rst(rst), .bus(vbus));

  // data array read port model
  assign bus.wb_rdata  = 16'hC0DE + {13'b0, bus.wb_index};
  assign vbus.wb_rdata = 32'h0;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int lat = 4;
  logic withhold = 1'b0;
  logic spur = 1'b0;
  logic real_valid = 1'b0;
  int pend_due[$];
  logic [15:0] pend_data[$];
  logic [15:0] rd_addr[$], wr_addr[$], wr_data[$], fd[$];
  logic [2:0]  fi[$];
  int tag_cnt, tag_at_fill, tag_cyc, fill_in_wb, cap_viol, stall_seen, stall_left;
  logic [15:0] stall_addr;
  logic last_busy, last_req;

  function automatic logic [15:0] rdata_of(logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  task automatic clear_logs();
    pend_due.delete(); pend_data.delete();
    rd_addr.delete(); wr_addr.delete(); wr_data.delete(); fd.delete(); fi.delete();
    tag_cnt = 0; tag_at_fill = 0; tag_cyc = 0; fill_in_wb = 0; cap_viol = 0;
    stall_seen = 0; stall_left = 0; stall_addr = 16'hFFFF;
  endtask

  // One clock of the default instance with a reactive in-order memory model.
  task automatic tick();
    @(negedge clk);
    last_busy = bus.fsm_busy;
    last_req  = bus.mem_req;
    if (bus.mem_req && !bus.mem_ready && bus.mem_address == stall_addr) stall_seen++;
    if (bus.mem_req && bus.mem_ready) begin
      if (bus.mem_we) begin
        wr_addr.push_back(bus.mem_address);
        wr_data.push_back(bus.mem_wdata);
      end else begin
        if (pend_due.size() + (real_valid ? 1 : 0) >= 4) cap_viol++;
        rd_addr.push_back(bus.mem_address);
        pend_due.push_back(cyc + lat);
        pend_data.push_back(rdata_of(bus.mem_address));
      end
    end
    if (bus.write_data_array) begin
      fi.push_back(bus.fill_index);
      fd.push_back(bus.fill_data);
      if (bus.mem_we) fill_in_wb++;
    end
    if (bus.write_tag_array) begin
      tag_cnt++;
      tag_at_fill = fi.size();
      tag_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!withhold && pend_due.size() > 0 && pend_due[0] <= cyc) begin
      real_valid = 1'b1;
      bus.mem_data_valid = 1'b1;
      bus.mem_rdata = pend_data.pop_front();
      void'(pend_due.pop_front());
    end else begin
      real_valid = 1'b0;
      bus.mem_data_valid = (pend_due.size() == 0) ? spur : 1'b0;
      bus.mem_rdata = 16'hDEAD;
    end
    if (stall_left > 0 && bus.mem_req && bus.mem_address == stall_addr) begin
      bus.mem_ready = 1'b0;
      stall_left--;
    end else begin
      bus.mem_ready = 1'b1;
    end
  endtask

  task automatic run_until_tag(input int budget);
    int n = 0;
    while (tag_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    n_chk++;
    if (tag_cnt == 0) $display("FAIL tag_timeout: no tag write within %0d cycles, required 1", budget);
    else n_pass++;
  endtask

  task automatic start_miss(input logic [15:0] ma, input logic dirty, input logic [15:0] va);
    bus.miss_detected = 1'b1;
    bus.miss_address = ma;
    bus.victim_dirty = dirty;
    bus.victim_address = va;
    tick();
    bus.miss_detected = 1'b0;
    bus.miss_address = 16'hBEEF;
    bus.victim_dirty = ~dirty;
    bus.victim_address = 16'h7770;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.miss_detected = 1'b1;
    tick();
    n_chk++; if (last_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", last_busy); else n_pass++;
    n_chk++; if (last_req !== 1'b0) $display("FAIL reset_req: got %b want 0", last_req); else n_pass++;
    bus.miss_detected = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    n_chk++; if (last_busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", last_busy); else n_pass++;
    n_chk++; if (tag_cnt !== 0) $display("FAIL reset_tag: got %0d want 0", tag_cnt); else n_pass++;
  endtask

  task automatic test_clean_miss();
    int start;
    clear_logs(); spur = 1'b1;
    start = cyc;
    start_miss(16'h1234, 1'b0, 16'hFFF0);
    n_chk++; if (last_busy !== 1'b1) $display("FAIL clean_idle_busy: got %b want 1", last_busy); else n_pass++;
    n_chk++; if (last_req !== 1'b0) $display("FAIL clean_idle_req: got %b want 0", last_req); else n_pass++;
    run_until_tag(60);
    n_chk++; if (tag_cyc - start !== 13) $display("FAIL clean_penalty: got %0d want 13", tag_cyc - start); else n_pass++;
    tick();
    n_chk++; if (last_busy !== 1'b0) $display("FAIL clean_busy_fall: got %b want 0", last_busy); else n_pass++;
    repeat (3) tick();
    n_chk++; if (rd_addr.size() !== 8) $display("FAIL clean_nreq: got %0d want 8", rd_addr.size()); else n_pass++;
    for (int i = 0; i < 8 && i < rd_addr.size(); i++) begin
      n_chk++;
      if (rd_addr[i] !== 16'h1230 + 16'(2*i)) $display("FAIL clean_addr[%0d]: got %h want %h", i, rd_addr[i], 16'h1230 + 16'(2*i));
      else n_pass++;
    end
    n_chk++; if (fi.size() !== 8) $display("FAIL clean_nfill: got %0d want 8", fi.size()); else n_pass++;
    for (int i = 0; i < 8 && i < fi.size(); i++) begin
      n_chk++;
      if (fi[i] !== 3'(i) || fd[i] !== rdata_of(16'h1230 + 16'(2*i)))
        $display("FAIL clean_fill[%0d]: got idx %0d data %h want idx %0d data %h", i, fi[i], fd[i], i, rdata_of(16'h1230 + 16'(2*i)));
      else n_pass++;
    end
    n_chk++; if (tag_cnt !== 1) $display("FAIL clean_tag_cnt: got %0d want 1", tag_cnt); else n_pass++;
    n_chk++; if (tag_at_fill !== 8) $display("FAIL clean_tag_with_last: got %0d want 8", tag_at_fill); else n_pass++;
  endtask

  task automatic test_dirty_miss();
    clear_logs(); spur = 1'b1;
    start_miss(16'h0040, 1'b1, 16'hA5F0);
    run_until_tag(80);
    repeat (3) tick();
    n_chk++; if (wr_addr.size() !== 8) $display("FAIL dirty_nwr: got %0d want 8", wr_addr.size()); else n_pass++;
    for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
      n_chk++;
      if (wr_addr[i] !== 16'hA5F0 + 16'(2*i) || wr_data[i] !== 16'hC0DE + 16'(i))
        $display("FAIL dirty_wr[%0d]: got addr %h data %h want addr %h data %h", i, wr_addr[i], wr_data[i], 16'hA5F0 + 16'(2*i), 16'hC0DE + 16'(i));
      else n_pass++;
    end
    n_chk++; if (fill_in_wb !== 0) $display("FAIL dirty_wb_array_write: got %0d want 0", fill_in_wb); else n_pass++;
    n_chk++; if (rd_addr.size() !== 8) $display("FAIL dirty_nreq: got %0d want 8", rd_addr.size()); else n_pass++;
    for (int i = 0; i < 8 && i < rd_addr.size(); i++) begin
      n_chk++;
      if (rd_addr[i] !== 16'h0040 + 16'(2*i)) $display("FAIL dirty_addr[%0d]: got %h want %h", i, rd_addr[i], 16'h0040 + 16'(2*i));
      else n_pass++;
    end
    n_chk++; if (fi.size() !== 8) $display("FAIL dirty_nfill: got %0d want 8", fi.size()); else n_pass++;
    n_chk++; if (tag_cnt !== 1) $display("FAIL dirty_tag_cnt: got %0d want 1", tag_cnt); else n_pass++;
  endtask

  task automatic test_outstanding_cap();
    clear_logs(); spur = 1'b0; withhold = 1'b1;
    start_miss(16'h1234, 1'b0, 16'h0000);
    repeat (11) tick();
    n_chk++; if (rd_addr.size() !== 4) $display("FAIL cap_nreq: got %0d want 4", rd_addr.size()); else n_pass++;
    n_chk++; if (last_req !== 1'b0) $display("FAIL cap_req_low: got %b want 0", last_req); else n_pass++;
    withhold = 1'b0;
    run_until_tag(80);
    repeat (3) tick();
    n_chk++; if (rd_addr.size() !== 8) $display("FAIL cap_total_req: got %0d want 8", rd_addr.size()); else n_pass++;
    n_chk++; if (fi.size() !== 8) $display("FAIL cap_total_fill: got %0d want 8", fi.size()); else n_pass++;
    n_chk++; if (cap_viol !== 0) $display("FAIL cap_exceeded: got %0d want 0", cap_viol); else n_pass++;
  endtask

  task automatic test_backpressure();
    clear_logs(); spur = 1'b0;
    stall_addr = 16'h1236; stall_left = 3;
    start_miss(16'h1234, 1'b0, 16'h0000);
    run_until_tag(80);
    repeat (3) tick();
    n_chk++; if (stall_seen !== 3) $display("FAIL bp_stall_cycles: got %0d want 3", stall_seen); else n_pass++;
    n_chk++; if (rd_addr.size() !== 8) $display("FAIL bp_nreq: got %0d want 8", rd_addr.size()); else n_pass++;
    for (int i = 0; i < 8 && i < rd_addr.size(); i++) begin
      n_chk++;
      if (rd_addr[i] !== 16'h1230 + 16'(2*i)) $display("FAIL bp_addr[%0d]: got %h want %h", i, rd_addr[i], 16'h1230 + 16'(2*i));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_fill();
    int n = 0;
    clear_logs(); spur = 1'b1;
    start_miss(16'h1234, 1'b0, 16'h0000);
    while (fi.size() < 3 && n < 40) begin tick(); n++; end
    n_chk++; if (fi.size() !== 3) $display("FAIL rst_mid_progress: got %0d want 3", fi.size()); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pend_due.delete(); pend_data.delete();
    bus.mem_data_valid = 1'b1;
    tick();
    n_chk++; if (last_busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", last_busy); else n_pass++;
    repeat (4) tick();
    n_chk++; if (tag_cnt !== 0) $display("FAIL rst_mid_tag: got %0d want 0", tag_cnt); else n_pass++;
    n_chk++; if (fi.size() !== 3) $display("FAIL rst_mid_writes: got %0d want 3", fi.size()); else n_pass++;
    clear_logs();
    start_miss(16'h2000, 1'b0, 16'h0000);
    run_until_tag(60);
    repeat (3) tick();
    n_chk++; if (rd_addr.size() !== 8) $display("FAIL rst_new_nreq: got %0d want 8", rd_addr.size()); else n_pass++;
    n_chk++; if (rd_addr.size() > 0 && rd_addr[0] !== 16'h2000) $display("FAIL rst_new_first: got %h want 2000", rd_addr[0]); else n_pass++;
    n_chk++; if (rd_addr.size() > 7 && rd_addr[7] !== 16'h200E) $display("FAIL rst_new_last: got %h want 200e", rd_addr[7]); else n_pass++;
    n_chk++; if (tag_cnt !== 1 || tag_at_fill !== 8) $display("FAIL rst_new_tag: got cnt %0d at %0d want 1 at 8", tag_cnt, tag_at_fill); else n_pass++;
  endtask

  task automatic test_variant();
    int k_req = 0, k_rsp = 0, vtag = 0, due = 0;
    logic pending = 1'b0;
    vbus.miss_detected = 1'b1;
    vbus.miss_address = 32'h0000_1F1C;
    vbus.victim_dirty = 1'b0;
    for (int n = 0; n < 40 && vtag == 0; n++) begin
      @(negedge clk);
      if (vbus.mem_req && vbus.mem_ready) begin
        n_chk++;
        if (vbus.mem_address !== 32'h1F10 + 32'(4*k_req) || vbus.mem_we !== 1'b0)
          $display("FAIL var_addr[%0d]: got %h we %b want %h we 0", k_req, vbus.mem_address, vbus.mem_we, 32'h1F10 + 32'(4*k_req));
        else n_pass++;
        n_chk++;
        if (pending || vbus.mem_data_valid) $display("FAIL var_one_at_a_time[%0d]: got issue with read outstanding, want none", k_req);
        else n_pass++;
        pending = 1'b1; due = n + 2; k_req++;
      end
      if (vbus.write_data_array) begin
        n_chk++;
        if (vbus.fill_index !== 2'(k_rsp) || vbus.fill_data !== 32'hF00D0000 + 32'(k_rsp))
          $display("FAIL var_fill[%0d]: got idx %0d data %h want idx %0d data %h", k_rsp, vbus.fill_index, vbus.fill_data, k_rsp, 32'hF00D0000 + 32'(k_rsp));
        else n_pass++;
        k_rsp++;
      end
      if (vbus.write_tag_array) begin
        vtag++;
        n_chk++; if (k_rsp !== 4) $display("FAIL var_tag_pos: got %0d want 4", k_rsp); else n_pass++;
      end
      @(posedge clk);
      #1;
      vbus.miss_detected = 1'b0;
      if (pending && n + 1 == due) begin
        vbus.mem_data_valid = 1'b1;
        vbus.mem_rdata = 32'hF00D0000 + 32'(k_rsp);
        pending = 1'b0;
      end else begin
        vbus.mem_data_valid = 1'b0;
      end
    end
    n_chk++; if (vtag !== 1) $display("FAIL var_tag_cnt: got %0d want 1", vtag); else n_pass++;
    n_chk++; if (k_req !== 4) $display("FAIL var_nreq: got %0d want 4", k_req); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    bus.miss_detected = 1'b0; bus.miss_address = '0; bus.victim_dirty = 1'b0; bus.victim_address = '0;
    bus.mem_ready = 1'b1; bus.mem_data_valid = 1'b0; bus.mem_rdata = '0;
    vbus.miss_detected = 1'b0; vbus.miss_address = '0; vbus.victim_dirty = 1'b0; vbus.victim_address = '0;
    vbus.mem_ready = 1'b1; vbus.mem_data_valid = 1'b0; vbus.mem_rdata = '0;
    clear_logs();
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_outstanding_cap();
    test_backpressure();
    test_reset_mid_fill();
    test_variant();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
Parametrised miss-handling FSM for the write-back data cache. It replaces the single-outstanding 8-word fill sequencer. When a miss occurs and the victim line is dirty, it writes the victim line back first. It then fills the missed line with up to MAX_OUTSTANDING pipelined memory reads, with backpressure on request issue. It sits between the cache data/tag arrays and the multi-cycle memory port.

Parameters:
ADDR_W, 16, byte-address width.
WORD_BYTES, 2, bytes per memory word (power of 2, >=1).
BLOCK_WORDS, 8, words per cache line (power of 2, >=2).
MAX_OUTSTANDING, 4, maximum issued-but-unanswered read requests (1..BLOCK_WORDS).
Derived: BO_W=log2(WORD_BYTES), CNT_W=log2(BLOCK_WORDS), OFF_W=CNT_W+BO_W, DATA_W=8*WORD_BYTES.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
miss_detected  in  1  miss request from cache, level
miss_address  in  ADDR_W  missing byte address
victim_dirty  in  1  victim line dirty, sampled with miss
victim_address  in  ADDR_W  victim line base address, sampled with miss
wb_rdata  in  DATA_W  data-array word at wb_index (combinational read)
mem_ready  in  1  memory accepts request this cycle
mem_data_valid  in  1  in-order read data return
mem_rdata  in  DATA_W  read data
fsm_busy  out  1  stall to pipeline
mem_req  out  1  request valid
mem_we  out  1  1=write, 0=read
mem_address  out  ADDR_W  word-aligned request address
mem_wdata  out  DATA_W  write data (=wb_rdata)
wb_index  out  CNT_W  data-array word being written back
write_data_array  out  1  write fill_data at fill_index
fill_index  out  CNT_W  data-array word being filled
fill_data  out  DATA_W  =mem_rdata
write_tag_array  out  1  commit tag/valid, clear dirty

Behaviour:
- States: IDLE, WB, FILL. Registers: state, line_base (ADDR_W-OFF_W bits), victim_base, req_cnt, resp_cnt (CNT_W+1 bits each), outstanding (log2(MAX_OUTSTANDING)+1 bits).
- rst: state=IDLE, all counters 0. All outputs are 0 in the same or next cycle; nothing is written. Reset mid-WB or mid-FILL aborts with no tag write.
- IDLE: fsm_busy=miss_detected (combinational). On miss_detected, latch miss_address[ADDR_W-1:OFF_W] and victim_address[ADDR_W-1:OFF_W], and clear counters. Next state is WB if victim_dirty, else FILL. No memory request is made in the IDLE cycle.
- WB: fsm_busy=1, mem_we=1, mem_req=1 while req_cnt<BLOCK_WORDS.
  - mem_address={victim_base, req_cnt[CNT_W-1:0], BO_W'b0}; wb_index=req_cnt; mem_wdata=wb_rdata.
  - A write is accepted when mem_req&mem_ready, and req_cnt increments.
  - On the cycle the last word is accepted: go to FILL and clear req_cnt.
  - Writes need no response. mem_data_valid is ignored in WB.
- FILL: fsm_busy=1, mem_we=0, mem_req=(req_cnt<BLOCK_WORDS)&(outstanding<MAX_OUTSTANDING).
  - mem_address={line_base, req_cnt[CNT_W-1:0], BO_W'b0}.
  - Issue (mem_req&mem_ready): req_cnt++, outstanding++.
  - Response (mem_data_valid): write_data_array=1, fill_index=resp_cnt, resp_cnt++, outstanding--.
  - Issue and response in the same cycle leave outstanding unchanged.
  - On the response with resp_cnt==BLOCK_WORDS-1: write_tag_array=1 (same cycle as the last data write), next state IDLE.
  - fsm_busy stays 1 through that cycle and is 0 from the next cycle, unless a new miss is present.
- While mem_ready=0, mem_address, mem_we and mem_wdata are held stable.
- mem_data_valid in IDLE or WB, or with outstanding==0, is ignored (no array write).
- Changes on miss_detected, miss_address or victim_* while not IDLE are ignored.
- Minimum miss penalty for a clean miss with MAX_OUTSTANDING>=BLOCK_WORDS, mem_ready=1 and response latency L: 1+BLOCK_WORDS-1+L cycles to the tag write.

Test Plan:
- Clean miss, defaults, miss_address=0x1234, mem_ready=1, each valid 4 cycles after its request -> reads to 0x1230,0x1232,…,0x123E. fill_index 0..7, one write_data_array per valid, write_tag_array exactly once with the 8th valid. fsm_busy falls the next cycle.
- Dirty miss, victim_address=0xA5F0, miss_address=0x0040 -> 8 writes to 0xA5F0..0xA5FE, wb_index 0..7, mem_wdata tracks wb_rdata. Then 8 reads 0x0040..0x004E. No array writes during WB.
- Outstanding cap: memory withholds valids -> exactly 4 read requests issue, then mem_req=0. Each later valid releases one more request; totals end at 8/8.
- Backpressure: mem_ready=0 for 3 cycles mid-fill at 0x1236 -> mem_address stays 0x1236, req_cnt frozen. Resumes on ready.
- Reset after 3 fill responses -> next cycle IDLE, busy=0, no tag write. A new miss to 0x2000 fills from 0x2000.
- Variant ADDR_W=32, WORD_BYTES=4, BLOCK_WORDS=4, MAX_OUTSTANDING=1 with miss 0x0000_1F1C -> reads 0x1F10,0x1F14,0x1F18,0x1F1C strictly one at a time. Tag write on the 4th valid.
